// File: rtl/puc_gate_sequencer.sv
// One-hot switching-state request to gate pattern, with turn-on blanking and sticky fault.
// Sits between the modulator and the gate-driver pins; all outputs are registered.
module puc_gate_sequencer #(
    parameter int unsigned                N_STATES = 8,
    parameter int unsigned                N_SW     = 6,
    parameter int unsigned                DEADTIME = 4,
    parameter logic [N_STATES*N_SW-1:0]   TABLE    = 48'h55CC781CE8EA
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic [N_STATES-1:0]         i_state_sel,
    input  logic                        i_fault_clr,
    output logic [N_SW-1:0]             o_gate,
    output logic [$clog2(N_STATES)-1:0] o_state_idx,
    output logic                        o_dt_active,
    output logic                        o_fault
);

    localparam int unsigned IDX_W = $clog2(N_STATES);
    localparam int unsigned CNT_W = $clog2(DEADTIME + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDead, StFault} state_e;

    state_e             r_state;
    logic [N_SW-1:0]    r_gate;
    logic [N_SW-1:0]    r_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_state_idx;
    logic               r_dt_active;
    logic               r_fault;

    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [N_SW-1:0]    w_pat;

    // Request bit N_STATES-1 selects state 0.
    always_comb begin
        w_idx = '0;
        for (int b = 0; b < int'(N_STATES); b++) begin
            if (i_state_sel[b]) w_idx = IDX_W'(int'(N_STATES) - 1 - b);
        end
    end

    assign w_valid = $onehot(i_state_sel);
    assign w_pat   = TABLE[int'(w_idx) * int'(N_SW) +: N_SW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_gate      <= '0;
            r_pend      <= '0;
            r_cnt       <= '0;
            r_state_idx <= '0;
            r_dt_active <= 1'b0;
            r_fault     <= 1'b0;
        end else if (r_state != StFault && i_en && !w_valid) begin
            r_state     <= StFault;
            r_gate      <= '0;
            r_fault     <= 1'b1;
            r_dt_active <= 1'b0;
        end else if (r_state != StFault && !i_en) begin
            r_state     <= StIdle;
            r_gate      <= '0;
            r_dt_active <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // First turn-on after idle is always blanked.
                    r_pend      <= w_pat;
                    r_cnt       <= CNT_LOAD;
                    r_gate      <= '0;
                    r_dt_active <= 1'b1;
                    r_state     <= StDead;
                end
                StRun: begin
                    if (w_pat == r_gate) begin
                        r_state <= StRun;
                    end else if ((w_pat & ~r_gate) == '0) begin
                        r_gate      <= w_pat;
                        r_state_idx <= w_idx;
                    end else begin
                        r_gate      <= r_gate & w_pat;
                        r_pend      <= w_pat;
                        r_cnt       <= CNT_LOAD;
                        r_dt_active <= 1'b1;
                        r_state     <= StDead;
                    end
                end
                StDead: begin
                    if (w_pat != r_pend) begin
                        // Retargeting only ever drops bits, so blanking restarts from here.
                        r_pend <= w_pat;
                        r_gate <= r_gate & w_pat;
                        r_cnt  <= CNT_LOAD;
                    end else if (r_cnt == '0) begin
                        r_gate      <= r_pend;
                        r_state_idx <= w_idx;
                        r_dt_active <= 1'b0;
                        r_state     <= StRun;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StFault: begin
                    r_gate <= '0;
                    if (i_fault_clr && !i_en) begin
                        r_fault <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_gate      = r_gate;
    assign o_state_idx = r_state_idx;
    assign o_dt_active = r_dt_active;
    assign o_fault     = r_fault;

endmodule

// File: tb/tb_puc_gate_sequencer.sv
// Bench for puc_gate_sequencer: time-based behavioural model, directed vectors,
// and a blanking-gap monitor on two instances (default table and a subset table).
module tb_puc_gate_sequencer;

    localparam int DT = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] sel;
    logic       clr;

    logic [5:0] gate,  gate_c;
    logic [2:0] idx,   idx_c;
    logic       dt,    dt_c;
    logic       fault, fault_c;

    int vectors     = 0;
    int miscompares = 0;

    puc_gate_sequencer #(.N_STATES(8), .N_SW(6), .DEADTIME(DT),
                         .TABLE(48'h55CC781CE8EA)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_state_sel(sel), .i_fault_clr(clr),
        .o_gate(gate), .o_state_idx(idx), .o_dt_active(dt), .o_fault(fault)
    );

    // state0 = 111000, state1 = 110000 (a strict subset of state0)
    puc_gate_sequencer #(.N_STATES(8), .N_SW(6), .DEADTIME(DT),
                         .TABLE(48'h55CC781CEC38)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_state_sel(sel), .i_fault_clr(clr),
        .o_gate(gate_c), .o_state_idx(idx_c), .o_dt_active(dt_c), .o_fault(fault_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: gate pattern as a function of request history and edge time.
    logic [5:0] m_tbl [8];
    logic [5:0] m_gate, m_target;
    logic [2:0] m_idx;
    logic       m_dt, m_fault, m_active, m_blank;
    int         m_edge, m_start;

    initial begin
        m_tbl[0] = 6'b101010; m_tbl[1] = 6'b100011; m_tbl[2] = 6'b001110;
        m_tbl[3] = 6'b000111; m_tbl[4] = 6'b111000; m_tbl[5] = 6'b110001;
        m_tbl[6] = 6'b011100; m_tbl[7] = 6'b010101;
    end

    task automatic model_edge();
        int         k;
        logic [5:0] n;
        logic       valid;
        m_edge++;
        valid = ($countones(sel) == 1);
        k = 0;
        for (int i = 0; i < 8; i++) if (sel == (8'h80 >> i)) k = i;
        n = m_tbl[k];
        if (m_fault) begin
            if (clr && !en) m_fault = 1'b0;
        end else if (en && !valid) begin
            m_fault = 1'b1; m_gate = '0; m_dt = 1'b0; m_active = 1'b0; m_blank = 1'b0;
        end else if (!en) begin
            m_gate = '0; m_dt = 1'b0; m_active = 1'b0; m_blank = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1; m_blank = 1'b1; m_dt = 1'b1; m_target = n; m_start = m_edge;
        end else if (m_blank) begin
            if (n != m_target) begin
                m_target = n; m_gate = m_gate & n; m_start = m_edge;
            end else if (m_edge - m_start == DT) begin
                m_gate = n; m_idx = 3'(k); m_dt = 1'b0; m_blank = 1'b0;
            end
        end else if (n != m_gate) begin
            if ((n & ~m_gate) == '0) begin
                m_gate = n; m_idx = 3'(k);
            end else begin
                m_gate = m_gate & n; m_target = n; m_start = m_edge;
                m_blank = 1'b1; m_dt = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_gate = '0; m_target = '0; m_idx = '0; m_dt = 1'b0; m_fault = 1'b0;
            m_active = 1'b0; m_blank = 1'b0; m_edge = 0; m_start = 0;
        end else begin
            model_edge();
        end
    end

    // Compare process plus blanking-gap monitor.
    int         ncyc = 0;
    logic [5:0] prev_g = '0, prev_gc = '0;
    int         lf = -100, lf_c = -100;

    always @(negedge clk) begin
        ncyc++;
        vectors++;
        if ({gate, idx, dt, fault} !== {m_gate, m_idx, m_dt, m_fault}) begin
            miscompares++;
            $display("FAIL model @%0t: gate=%b idx=%0d dt=%b fault=%b, want gate=%b idx=%0d dt=%b fault=%b",
                     $time, gate, idx, dt, fault, m_gate, m_idx, m_dt, m_fault);
        end
        if ((gate & ~prev_g) != '0) begin
            vectors++;
            if ((prev_g & ~gate) != '0 || ncyc - lf < DT) begin
                miscompares++;
                $display("FAIL deadtime @%0t: rise %b only %0d cycles after fall, need >= %0d",
                         $time, gate & ~prev_g, ncyc - lf, DT);
            end
        end
        if ((prev_g & ~gate) != '0) lf = ncyc;
        prev_g = gate;
        if ((gate_c & ~prev_gc) != '0) begin
            vectors++;
            if ((prev_gc & ~gate_c) != '0 || ncyc - lf_c < DT) begin
                miscompares++;
                $display("FAIL deadtime_c @%0t: rise %b only %0d cycles after fall, need >= %0d",
                         $time, gate_c & ~prev_gc, ncyc - lf_c, DT);
            end
        end
        if ((prev_gc & ~gate_c) != '0) lf_c = ncyc;
        prev_gc = gate_c;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int perm [8];

    initial begin
        rst = 1'b1; en = 1'b0; sel = '0; clr = 1'b0;
        cyc(2);
        rst = 1'b0;
        check("reset gate", 32'(gate), 32'h0);
        check("reset idx", 32'(idx), 32'h0);
        check("reset dt", 32'(dt), 32'h0);
        check("reset fault", 32'(fault), 32'h0);

        // First turn-on is blanked for DT edges.
        en = 1'b1; sel = 8'h80;
        cyc(1);
        check("t1 blank gate", 32'(gate), 32'h0);
        check("t1 blank dt", 32'(dt), 32'h1);
        cyc(3);
        check("t1 blank dt end", 32'(dt), 32'h1);
        cyc(1);
        check("t1 gate", 32'(gate), 32'b101010);
        check("t1 idx", 32'(idx), 32'h0);
        check("t1 dt", 32'(dt), 32'h0);
        check("t5 c state0", 32'(gate_c), 32'b111000);

        // state0 -> state1; subset table turns off without blanking.
        sel = 8'h40;
        cyc(1);
        check("t2 overlap", 32'(gate), 32'b100010);
        check("t5 c gate", 32'(gate_c), 32'b110000);
        check("t5 c dt", 32'(dt_c), 32'h0);
        check("t5 c idx", 32'(idx_c), 32'h1);
        cyc(3);
        check("t2 overlap held", 32'(gate), 32'b100010);
        cyc(1);
        check("t2 gate", 32'(gate), 32'b100011);
        check("t2 idx", 32'(idx), 32'h1);

        // Retarget mid-blanking restarts the interval.
        sel = 8'h80;
        cyc(5);
        check("t3 back to s0", 32'(gate), 32'b101010);
        sel = 8'h40;
        cyc(2);
        sel = 8'h20;
        cyc(1);
        check("t3 restart gate", 32'(gate), 32'b000010);
        check("t3 restart dt", 32'(dt), 32'h1);
        cyc(3);
        check("t3 still blank", 32'(gate), 32'b000010);
        cyc(1);
        check("t3 gate", 32'(gate), 32'b001110);
        check("t3 idx", 32'(idx), 32'h2);

        // en=0 aborts a blanking interval.
        sel = 8'h80;
        cyc(1);
        check("abort dt before", 32'(dt), 32'h1);
        en = 1'b0;
        cyc(1);
        check("abort gate", 32'(gate), 32'h0);
        check("abort dt", 32'(dt), 32'h0);
        cyc(1);

        // Illegal requests fault; clear honoured only with en=0.
        en = 1'b1; sel = 8'hC0;
        cyc(1);
        check("t4 fault", 32'(fault), 32'h1);
        check("t4 gate", 32'(gate), 32'h0);
        check("t4 c fault", 32'(fault_c), 32'h1);
        clr = 1'b1;
        cyc(2);
        check("t4 clr ignored", 32'(fault), 32'h1);
        en = 1'b0;
        cyc(1);
        check("t4 cleared", 32'(fault), 32'h0);
        clr = 1'b0; en = 1'b1; sel = 8'h00;
        cyc(1);
        check("t4 zero req fault", 32'(fault), 32'h1);
        en = 1'b0; clr = 1'b1;
        cyc(1);
        clr = 1'b0; en = 1'b1; sel = 8'h01;
        cyc(1);
        check("t4 idle restart dt", 32'(dt), 32'h1);
        cyc(DT);
        check("t4 state7", 32'(gate), 32'b010101);
        check("t4 idx7", 32'(idx), 32'h7);

        // Asynchronous reset mid-blanking.
        sel = 8'h80;
        cyc(1);
        check("t6 overlap", 32'(gate), 32'b000000 | (6'b010101 & 6'b101010));
        sel = 8'h04;
        cyc(DT + 1);
        sel = 8'h80;
        cyc(1);
        check("t6 pre-rst dt", 32'(dt), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("t6 async gate", 32'(gate), 32'h0);
        check("t6 async dt", 32'(dt), 32'h0);
        cyc(1);
        rst = 1'b0;

        // Randomised sweep over all states with mixed hold times.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(0, i));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 8; i++) begin
                sel = 8'h80 >> perm[i];
                cyc(int'($urandom_range(1, DT + 3)));
            end
        end
        en = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
